// File: rtl/psum_collector.sv
// Drain block for one PE column: tracks valid psums out of the last PE,
// accumulates K-tiled passes and queues finished results for downstream.
module psum_collector #(
  parameter int accumulationPar = 32,
  parameter int rows            = 4,
  parameter int passes          = 4,
  parameter int fifoDepth       = 4,
  localparam int idxW = (passes > 1) ? $clog2(passes) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inj_valid,
  input  logic [accumulationPar-1:0] psumIn,
  input  logic                       flush,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [accumulationPar-1:0] out_data,
  output logic [idxW-1:0]            pass_idx,
  output logic                       overflow
);

  localparam int L  = 2 * rows;
  localparam int aw = $clog2(fifoDepth);

  logic [L-1:0]               dly;
  logic                       psumValid;
  logic [accumulationPar-1:0] acc;
  logic [idxW-1:0]            passIdx;
  logic                       isLast;
  logic                       complete;
  logic [accumulationPar-1:0] result;

  logic [accumulationPar-1:0] mem [fifoDepth];
  logic [aw-1:0]              rdPtr;
  logic [aw-1:0]              wrPtr;
  logic [aw:0]                count;
  logic                       full;
  logic                       pop;
  logic                       doPush;
  logic                       ovf;

  assign psumValid = dly[L-1];
  assign isLast    = (passIdx == idxW'(passes - 1));
  assign complete  = psumValid && isLast && !flush;
  // First pass overwrites acc, so result never depends on a stale acc.
  assign result    = (passIdx == '0) ? psumIn : acc + psumIn;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      dly     <= '0;
      acc     <= '0;
      passIdx <= '0;
    end else begin
      dly <= {dly[L-2:0], inj_valid};
      if (psumValid) begin
        acc     <= result;
        passIdx <= isLast ? '0 : passIdx + 1'b1;
      end
    end
  end

  assign full   = (count == (aw + 1)'(fifoDepth));
  assign pop    = (count != '0) && out_ready;
  assign doPush = complete && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < fifoDepth; i++) begin
        mem[i] <= '0;
      end
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= result;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
      end
      if (doPush && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !doPush) begin
        count <= count - 1'b1;
      end
      if (complete && full && !pop) begin
        ovf <= 1'b1;
      end
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rdPtr] : '0;
  assign pass_idx  = passIdx;
  assign overflow  = ovf;

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: reset, accumulation, wrap,
// backpressure/overflow, full push+pop and flush.
module tb_psum_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        inj_valid;
  logic [31:0] psumIn;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  pass_idx;
  logic        overflow;

  int errs   = 0;
  int checks = 0;

  psum_collector #(
    .accumulationPar(32),
    .rows(4),
    .passes(4),
    .fifoDepth(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inj_valid(inj_valid),
    .psumIn(psumIn),
    .flush(flush),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .pass_idx(pass_idx),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inject 4 psums in cycles 0-3, feed values in cycles 8-11.
  // Returns in cycle 12. readyLast raises out_ready in cycle 11 only.
  task automatic runResult(input logic [31:0] v0, input logic [31:0] v1,
                           input logic [31:0] v2, input logic [31:0] v3,
                           input bit readyLast);
    logic [31:0] v [4];
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      inj_valid = 1'b1;
      tick();
    end
    inj_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      psumIn    = v[i];
      out_ready = (i == 3) && readyLast;
      tick();
      chk("pass_idx", 32'(pass_idx), 32'((i + 1) % 4));
    end
    psumIn    = '0;
    out_ready = 1'b0;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    inj_valid = 1'b1;
    tick();
    tick();
    rst       = 1'b0;
    inj_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    inj_valid = 1'b0;
    psumIn    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // reset with inj_valid held high
    doReset();
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", out_data, 0);
    chk("rst pass_idx", 32'(pass_idx), 0);
    chk("rst overflow", 32'(overflow), 0);
    psumIn = 32'd9;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post-rst no psum", 32'(pass_idx), 0);
    end
    chk("post-rst empty", 32'(out_valid), 0);
    psumIn = '0;

    // basic accumulation
    runResult(1, 2, 3, 4, 1'b0);
    chk("basic out_valid", 32'(out_valid), 1);
    chk("basic out_data", out_data, 10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic popped", 32'(out_valid), 0);

    // modulo wrap
    runResult(32'hFFFF_FFFF, 1, 0, 32'h10, 1'b0);
    chk("wrap out_data", out_data, 32'h10);
    chk("wrap overflow", 32'(overflow), 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // backpressure and overflow
    for (int r = 1; r <= 5; r++) begin
      runResult(32'(10 * r), 0, 0, 0, 1'b0);
      chk("bp overflow", 32'(overflow), (r == 5) ? 1 : 0);
      chk("bp head held", out_data, 10);
    end
    out_ready = 1'b1;
    for (int r = 1; r <= 4; r++) begin
      chk("bp drain valid", 32'(out_valid), 1);
      chk("bp drain data", out_data, 32'(10 * r));
      tick();
    end
    out_ready = 1'b0;
    chk("bp empty", 32'(out_valid), 0);
    chk("bp empty data", out_data, 0);
    chk("bp sticky", 32'(overflow), 1);

    // full push+pop
    doReset();
    chk("rst2 overflow", 32'(overflow), 0);
    for (int r = 1; r <= 4; r++) begin
      runResult(32'(r), 0, 0, 0, 1'b0);
    end
    runResult(5, 0, 0, 0, 1'b1);
    chk("pp overflow", 32'(overflow), 0);
    out_ready = 1'b1;
    for (int r = 2; r <= 5; r++) begin
      chk("pp drain valid", 32'(out_valid), 1);
      chk("pp drain data", out_data, 32'(r));
      tick();
    end
    out_ready = 1'b0;
    chk("pp empty", 32'(out_valid), 0);

    // flush mid-pass
    for (int i = 0; i < 3; i++) begin
      inj_valid = 1'b1;
      tick();
    end
    inj_valid = 1'b0;
    repeat (5) tick();
    psumIn = 7;
    tick();
    tick();
    chk("fl pre idx", 32'(pass_idx), 2);
    flush = 1'b1;
    tick();
    flush  = 1'b0;
    psumIn = '0;
    chk("fl idx", 32'(pass_idx), 0);
    chk("fl no push", 32'(out_valid), 0);
    runResult(5, 5, 5, 5, 1'b0);
    chk("fl out_data", out_data, 20);
    chk("fl overflow", 32'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
